mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 123 ++++++++++++
 tb/tb_mem_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port word memory answering one read/write pulse at a time after LATENCY wait cycles.
// Optional `MEM_ALIGN_CHECK_EN adds mem_err and drops misaligned accesses.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        mem_err
`endif
);

    localparam int unsigned AW      = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LatLoad = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StCapture, StWait, StResp} state_e;

    state_e        state_q, state_d;
    logic          is_wr_q, is_wr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [AW-1:0] idx;
    logic          mis;
    logic          mem_we;
    logic [31:0]   mem_q [DEPTH_WORDS];
    logic          unused_addr;

    assign idx         = mem_addr[AW+1:2];
    assign unused_addr = ^{mem_addr[31:AW+2], mem_addr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
    logic err_q, err_d;
    assign mis = (mem_addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        is_wr_d = is_wr_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (mem_read || mem_write) begin
                    is_wr_d = mem_write;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                // Address/data are sampled here, one cycle after the request pulse.
                mem_we = is_wr_q && !mis;
                if (!is_wr_q || mis) begin
                    rdata_d = mis ? 32'h0 : mem_q[idx];
                end
`ifdef MEM_ALIGN_CHECK_EN
                err_d = mis;
`endif
                if (LATENCY == 0) begin
                    state_d = StResp;
                end else begin
                    state_d = StWait;
                    cnt_d   = LatLoad;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            is_wr_q <= 1'b0;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
`ifdef MEM_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
`ifdef MEM_ALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= mem_wdata;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_resp  = (state_q == StResp);
`ifdef MEM_ALIGN_CHECK_EN
    assign mem_err   = mem_resp && err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: driver pushes expected responses from a word-array model,
// a negedge monitor pops and checks response cycle, data and error flag.
module tb_mem_responder;

    localparam int unsigned Depth = 1024;
    localparam int unsigned Lat   = 2;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
        bit          err;
    } exp_t;

    logic        clk, rst_n;
    logic        mem_read, mem_write, mem_resp;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        b_read, b_write, b_resp;
    logic [31:0] b_addr, b_wdata, b_rdata;
`ifdef MEM_ALIGN_CHECK_EN
    logic        mem_err, b_err;
`endif

    int unsigned cyc;
    int          checks, errors;
    exp_t        exp_q[$];
    logic [31:0] model [Depth];
    logic [31:0] last_rd;
    bit          hold_chk;
    logic [31:0] hold_val;

    mem_responder #(.DEPTH_WORDS(Depth), .LATENCY(Lat)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_resp (mem_resp)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .mem_err  (mem_err)
`endif
    );

    mem_responder #(.DEPTH_WORDS(Depth), .LATENCY(0)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_read (b_read),
        .mem_write(b_write),
        .mem_addr (b_addr),
        .mem_wdata(b_wdata),
        .mem_rdata(b_rdata),
        .mem_resp (b_resp)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .mem_err  (b_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every response must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
                checks++;
                errors++;
                $display("FAIL missing_resp: no mem_resp by cycle %0d, expected at %0d",
                         cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (mem_resp) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: mem_resp=1 at cycle %0d, expected 0", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_cycle", cyc, e.due);
                    chk("resp_rdata", mem_rdata, e.data);
`ifdef MEM_ALIGN_CHECK_EN
                    chk("resp_err", {31'h0, mem_err}, {31'h0, e.err});
`endif
                    hold_chk = 1'b1;
                    hold_val = e.data;
                end
            end else if (hold_chk) begin
                chk("rdata_hold", mem_rdata, hold_val);
                hold_chk = 1'b0;
            end
        end
    end

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
    task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] stale);
        exp_t        e;
        int unsigned idx;
        bit          mis;
        idx = (addr >> 2) % Depth;
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (addr % 4) != 0;
`endif
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = stale;
        mem_wdata = $urandom();
        e.due = cyc + 2 + Lat;
        e.err = mis;
        if (wr) begin
            if (!mis) model[idx] = wdata;
            e.data = mis ? 32'h0 : last_rd;
        end else begin
            e.data = mis ? 32'h0 : model[idx];
        end
        last_rd = e.data;
        exp_q.push_back(e);
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = addr;
        mem_wdata = wdata;
        // Request pulses during WAIT/RESP must be ignored.
        repeat (Lat + 1) begin
            @(posedge clk); #1;
            mem_read  = 1'($urandom_range(0, 1));
            mem_write = 1'($urandom_range(0, 1));
            mem_addr  = $urandom();
            mem_wdata = $urandom();
        end
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        logic [31:0] r, addr, lo;
        int unsigned kind, idx;
        cyc = 0; checks = 0; errors = 0; last_rd = 32'h0; hold_chk = 1'b0; hold_val = 32'h0;
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
        b_read = 1'b0; b_write = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset_resp", {31'h0, mem_resp}, 32'h0);
        chk("reset_rdata", mem_rdata, 32'h0);
        chk("reset_resp_l0", {31'h0, b_resp}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) issue(1'b0, 1'b1, i * 4, $urandom(), $urandom());

        issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 32'h0);
        issue(1'b0, 1'b1, 32'h0, 32'h0000_0A0A, 32'h0);
        issue(1'b0, 1'b1, 32'h8, 32'h0000_2222, 32'h0);
        issue(1'b1, 1'b0, 32'h8, 32'h0, 32'h0);
        issue(1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5, 32'h0);
        issue(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);

        // Reset during WAIT aborts the read with no response.
        mem_read = 1'b1; mem_addr = 32'h0;
        @(posedge clk); #1;
        mem_read = 1'b0; mem_addr = 32'h10;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async_rdata", mem_rdata, 32'h0);
        chk("rst_async_resp", {31'h0, mem_resp}, 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_resp", {31'h0, mem_resp}, 32'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_rd = 32'h0;
        issue(1'b1, 1'b0, 32'h10, 32'h0, 32'h0);

`ifdef MEM_ALIGN_CHECK_EN
        issue(1'b0, 1'b1, 32'h4, 32'h1111_1111, 32'h0);
        issue(1'b0, 1'b1, 32'h6, 32'h9999_9999, 32'h0);
        issue(1'b1, 1'b0, 32'h4, 32'h0, 32'h0);
`endif

        for (int i = 0; i < 40; i++) begin
            r    = $urandom();
            idx  = $urandom_range(0, 15);
            kind = $urandom_range(0, 3);
            lo   = $urandom_range(0, 3);
`ifdef MEM_ALIGN_CHECK_EN
            if ($urandom_range(0, 3) != 0) lo = 32'h0;
`endif
            addr = (r & 32'hFFFF_F000) | (idx << 2) | lo;
            issue(kind < 2, kind >= 2, addr, $urandom(), $urandom());
        end

        repeat (8) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'h0);

        // LATENCY=0 instance: simultaneous read+write is a write, response at T+2.
        b_read = 1'b1; b_write = 1'b1; b_addr = 32'h0; b_wdata = 32'h0;
        @(negedge clk);
        chk("l0_resp_t", {31'h0, b_resp}, 32'h0);
        @(posedge clk); #1;
        b_read = 1'b0; b_write = 1'b0; b_addr = 32'h4; b_wdata = 32'h1234;
        @(negedge clk);
        chk("l0_resp_t1", {31'h0, b_resp}, 32'h0);
        @(posedge clk); #1;
        b_addr = 32'h0; b_wdata = 32'h0;
        @(negedge clk);
        chk("l0_wr_resp_t2", {31'h0, b_resp}, 32'h1);
        chk("l0_wr_rdata", b_rdata, 32'h0);
        @(posedge clk); #1;
        b_read = 1'b1;
        @(negedge clk);
        chk("l0_rd_resp_t", {31'h0, b_resp}, 32'h0);
        @(posedge clk); #1;
        b_read = 1'b0; b_addr = 32'h4;
        @(posedge clk); #1;
        b_addr = 32'h0;
        @(negedge clk);
        chk("l0_rd_resp_t2", {31'h0, b_resp}, 32'h1);
        chk("l0_rd_rdata", b_rdata, 32'h1234);
        @(posedge clk); #1;
        @(negedge clk);
        chk("l0_resp_single", {31'h0, b_resp}, 32'h0);
        chk("l0_rdata_hold", b_rdata, 32'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
